alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 195 +++++++++++++++++++
 tb/tb_alu_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester front end for a 16-bit combinational ALU: arbitrates commands and
// runs 32-bit operations as a low half followed by an optional high half.
module alu_sched #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_select,
  input  logic        req0_mode,
  input  logic        req0_carry_in,
  input  logic        req0_wide,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_select,
  input  logic        req1_mode,
  input  logic        req1_carry_in,
  input  logic        req1_wide,
  output logic        req1_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_select,
  output logic        alu_mode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_out,
  input  logic        alu_carry_out,
  input  logic        alu_compare,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_compare,
  input  logic        rsp_ready,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned SW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          mode_q, mode_d;
  logic          cin_q, cin_d;
  logic          wide_q, wide_d;
  logic          id_q, id_d;
  logic [DW-1:0] res_q, res_d;
  logic          carry_lo_q, carry_lo_d;
  logic          cmp_lo_q, cmp_lo_d;
  logic          rsp_carry_q, rsp_carry_d;
  logic          rsp_cmp_q, rsp_cmp_d;

  logic          gnt_any_c;
  logic          gnt_id_c;

  // Grant: a lone requester wins; on contention RR alternates, otherwise requester 0
  always_comb begin
    gnt_any_c = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id_c = (RR != 0) ? ~last_q : 1'b0;
    end else begin
      gnt_id_c = req1_valid;
    end
  end

  assign req0_ready = (state_q == S_IDLE) & gnt_any_c & ~gnt_id_c;
  assign req1_ready = (state_q == S_IDLE) & gnt_any_c &  gnt_id_c;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    wide_d      = wide_q;
    id_d        = id_q;
    res_d       = res_q;
    carry_lo_d  = carry_lo_q;
    cmp_lo_d    = cmp_lo_q;
    rsp_carry_d = rsp_carry_q;
    rsp_cmp_d   = rsp_cmp_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_select   = '0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_any_c) begin
          a_d     = gnt_id_c ? req1_a        : req0_a;
          b_d     = gnt_id_c ? req1_b        : req0_b;
          sel_d   = gnt_id_c ? req1_select   : req0_select;
          mode_d  = gnt_id_c ? req1_mode     : req0_mode;
          cin_d   = gnt_id_c ? req1_carry_in : req0_carry_in;
          wide_d  = gnt_id_c ? req1_wide     : req0_wide;
          id_d    = gnt_id_c;
          last_d  = gnt_id_c;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_a        = a_q[HW-1:0];
        alu_b        = b_q[HW-1:0];
        alu_select   = sel_q;
        alu_mode     = mode_q;
        alu_carry_in = cin_q;
        carry_lo_d   = alu_carry_out;
        cmp_lo_d     = alu_compare;
        if (wide_q) begin
          res_d   = {res_q[DW-1:HW], alu_out};
          state_d = S_HI;
        end else begin
          res_d       = {HW'(0), alu_out};
          rsp_carry_d = alu_carry_out;
          rsp_cmp_d   = alu_compare;
          state_d     = S_RESP;
        end
      end
      S_HI: begin
        alu_a        = a_q[DW-1:HW];
        alu_b        = b_q[DW-1:HW];
        alu_select   = sel_q;
        alu_mode     = mode_q;
        // Arithmetic mode chains the low-half carry; logic mode reuses the command carry
        alu_carry_in = mode_q ? cin_q : carry_lo_q;
        res_d        = {alu_out, res_q[HW-1:0]};
        rsp_carry_d  = alu_carry_out;
        rsp_cmp_d    = cmp_lo_q & alu_compare;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      wide_q      <= 1'b0;
      id_q        <= 1'b0;
      res_q       <= '0;
      carry_lo_q  <= 1'b0;
      cmp_lo_q    <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_cmp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      wide_q      <= wide_d;
      id_q        <= id_d;
      res_q       <= res_d;
      carry_lo_q  <= carry_lo_d;
      cmp_lo_q    <= cmp_lo_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_cmp_q   <= rsp_cmp_d;
    end
  end

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = id_q;
  assign rsp_data    = res_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_compare = rsp_cmp_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed commands against an adder ALU stub,
// with a second RR=0 instance sharing the request inputs for the priority check.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [3:0]  req_sel   [2];
  logic        req_mode  [2];
  logic        req_cin   [2];
  logic        req_wide  [2];
  logic        rsp_ready;

  logic        rdy0, rdy1, p_rdy0, p_rdy1;
  logic [15:0] alu_a, alu_b, alu_out, p_alu_a, p_alu_b, p_alu_out;
  logic [3:0]  alu_select, p_alu_select;
  logic        alu_mode, alu_cin, alu_cout, alu_cmp;
  logic        p_alu_mode, p_alu_cin, p_alu_cout, p_alu_cmp;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_compare, busy;
  logic [31:0] rsp_data, p_rsp_data;
  logic        p_rsp_valid, p_rsp_id, p_rsp_carry, p_rsp_compare, p_busy;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        carry;
    logic        cmp;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] snap_a   [8];
  logic [15:0] snap_b   [8];
  logic        snap_cin [8];

  always #5 clk = ~clk;

  // Adder ALU stubs
  assign {alu_cout, alu_out}     = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);
  assign alu_cmp                 = (alu_out == 16'h0);
  assign {p_alu_cout, p_alu_out} = 17'(p_alu_a) + 17'(p_alu_b) + 17'(p_alu_cin);
  assign p_alu_cmp               = (p_alu_out == 16'h0);

  alu_sched #(.RR(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_select(req_sel[0]), .req0_mode(req_mode[0]), .req0_carry_in(req_cin[0]),
    .req0_wide(req_wide[0]), .req0_ready(rdy0),
    .req1_valid(req_valid[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_select(req_sel[1]), .req1_mode(req_mode[1]), .req1_carry_in(req_cin[1]),
    .req1_wide(req_wide[1]), .req1_ready(rdy1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_carry_in(alu_cin), .alu_out(alu_out), .alu_carry_out(alu_cout),
    .alu_compare(alu_cmp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_compare(rsp_compare), .rsp_ready(rsp_ready), .busy(busy)
  );

  alu_sched #(.RR(0)) dut_pri (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_select(req_sel[0]), .req0_mode(req_mode[0]), .req0_carry_in(req_cin[0]),
    .req0_wide(req_wide[0]), .req0_ready(p_rdy0),
    .req1_valid(req_valid[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_select(req_sel[1]), .req1_mode(req_mode[1]), .req1_carry_in(req_cin[1]),
    .req1_wide(req_wide[1]), .req1_ready(p_rdy1),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_select(p_alu_select), .alu_mode(p_alu_mode),
    .alu_carry_in(p_alu_cin), .alu_out(p_alu_out), .alu_carry_out(p_alu_cout),
    .alu_compare(p_alu_cmp),
    .rsp_valid(p_rsp_valid), .rsp_id(p_rsp_id), .rsp_data(p_rsp_data),
    .rsp_carry(p_rsp_carry), .rsp_compare(p_rsp_compare), .rsp_ready(rsp_ready),
    .busy(p_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_data), 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
          chk("rsp_compare", 32'(rsp_compare), 32'(e.cmp));
        end
      end
    end
  end

  function automatic logic rdy(input int n);
    return (n == 1) ? rdy1 : rdy0;
  endfunction

  task automatic push(input logic [31:0] d, input logic id, input logic c, input logic m);
    exp_t e;
    e.data = d; e.id = id; e.carry = c; e.cmp = m;
    sb.push_back(e);
  endtask

  // Present one command and return one cycle after its accept edge, then scramble inputs
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic mode, input logic cin, input logic wide, output int waited);
    req_a[n] = a; req_b[n] = b; req_sel[n] = 4'h0;
    req_mode[n] = mode; req_cin[n] = cin; req_wide[n] = wide;
    req_valid[n] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rdy(n) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", 32'(rdy(n)), 32'h1);
    @(posedge clk);
    #1;
    req_valid[n] = 1'b0;
    req_a[n] = $urandom(); req_b[n] = $urandom();
    req_mode[n] = ~mode; req_cin[n] = ~cin; req_wide[n] = ~wide;
  endtask

  // Count edges from accept to first edge with rsp_valid high, snapshotting the ALU drive
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (lat < 8) begin
      @(negedge clk);
      snap_a[lat] = alu_a; snap_b[lat] = alu_b; snap_cin[lat] = alu_cin;
      if (rsp_valid) break;
      lat++;
    end
    if (lat >= 8) chk("rsp_timeout", 32'(rsp_valid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, lat, cnt;
    logic ord   [4];
    logic p_ord [4];

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_a[i] = '0; req_b[i] = '0; req_sel[i] = '0;
      req_mode[i] = 1'b0; req_cin[i] = 1'b0; req_wide[i] = 1'b0;
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      snap_a[i] = '0; snap_b[i] = '0; snap_cin[i] = 1'b0;
    end

    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_cin", 32'(alu_cin), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention right after reset: RR gives 0,1,0,1; fixed priority gives 0,0,0,0
    push(32'd3, 1'b0, 1'b0, 1'b0); push(32'd30, 1'b1, 1'b0, 1'b0);
    push(32'd3, 1'b0, 1'b0, 1'b0); push(32'd30, 1'b1, 1'b0, 1'b0);
    req_a[0] = 32'd1;  req_b[0] = 32'd2;
    req_a[1] = 32'd10; req_b[1] = 32'd20;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      @(negedge clk);
      while (!(rdy0 || rdy1) && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      ord[i] = rdy1;
      p_ord[i] = p_rdy1;
      @(posedge clk);
    end
    #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    chk("rr_order0", 32'(ord[0]), 32'h0);
    chk("rr_order1", 32'(ord[1]), 32'h1);
    chk("rr_order2", 32'(ord[2]), 32'h0);
    chk("rr_order3", 32'(ord[3]), 32'h1);
    for (int i = 0; i < 4; i++) chk("pri_order", 32'(p_ord[i]), 32'h0);
    repeat (4) @(posedge clk);
    #1;

    // Narrow add
    push(32'h0000_0007, 1'b0, 1'b0, 1'b0);
    issue(0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0, w);
    wait_rsp(lat);
    chk("narrow_lat", 32'(lat), 32'd2);
    chk("narrow_lo_a", 32'(snap_a[1]), 32'h3);
    chk("narrow_lo_b", 32'(snap_b[1]), 32'h4);
    @(posedge clk); #1;

    // Wide carry chain from requester 1
    push(32'h0002_0000, 1'b1, 1'b0, 1'b0);
    issue(1, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, w);
    wait_rsp(lat);
    chk("wide_lat", 32'(lat), 32'd3);
    chk("wide_lo_a", 32'(snap_a[1]), 32'hFFFF);
    chk("wide_hi_a", 32'(snap_a[2]), 32'h0001);
    chk("wide_hi_cin", 32'(snap_cin[2]), 32'h1);
    @(posedge clk); #1;

    // Mode 1 wide: high half uses the command carry, not the low-half carry
    push(32'hFFFE_FFFE, 1'b0, 1'b1, 1'b0);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, w);
    wait_rsp(lat);
    chk("mode1_lat", 32'(lat), 32'd3);
    chk("mode1_hi_cin", 32'(snap_cin[2]), 32'h0);
    @(posedge clk); #1;

    // Response backpressure with both requesters pending
    rsp_ready = 1'b0;
    push(32'h0000_1234, 1'b0, 1'b0, 1'b0);
    issue(0, 32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, 1'b0, w);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_valid[1] = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data", rsp_data, 32'h0000_1234);
      chk("bp_rdy0", 32'(rdy0), 32'h0);
      chk("bp_rdy1", 32'(rdy1), 32'h0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while the high half is in flight: command is dropped
    issue(0, 32'h0003_0001, 32'h0004_0002, 1'b0, 1'b0, 1'b1, w);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_alu_a", 32'(alu_a), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'h0000_000B, 1'b1, 1'b0, 1'b0);
    issue(1, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 1'b0, w);
    chk("postrst_first_edge", 32'(w), 32'h0);
    wait_rsp(lat);
    chk("postrst_lat", 32'(lat), 32'd2);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
